contador_decrescente_mod: RTL and testbench

Synchronous, loadable, modulo-MOD down counter. It is the counting-down counterpart to the team's ripple up-counter.
- All bits change on the same main_clock edge, so there is no ripple settling.
- The count wraps from 0 back to MOD-1.
- A borrow output allows several stages to be cascaded into multi-digit countdown timers (default configuration: BCD digit, 9 down to 0).

---
 rtl/contador_decrescente_mod_if.sv | 27 ++
 rtl/contador_decrescente_mod.sv | 93 +++++++++
 tb/tb_contador_decrescente_mod.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/contador_decrescente_mod_if.sv
// Bus bundle for the modulo-MOD down counter.
// master: drives load / load_val / cnt_en, observes the count and status.
// slave : the counter itself.
// Signals: load, load_val[WIDTH], cnt_en (controls); Q_output[WIDTH],
//          borrow_out, zero, wrap_pulse, load_err (status).
interface contador_decrescente_mod_if #(
  parameter int unsigned WIDTH = 5
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             cnt_en;
  logic [WIDTH-1:0] Q_output;
  logic             borrow_out;
  logic             zero;
  logic             wrap_pulse;
  logic             load_err;

  modport master (
    output load, load_val, cnt_en,
    input  Q_output, borrow_out, zero, wrap_pulse, load_err
  );

  modport slave (
    input  load, load_val, cnt_en,
    output Q_output, borrow_out, zero, wrap_pulse, load_err
  );
endinterface

// File: rtl/contador_decrescente_mod.sv
// Synchronous loadable modulo-MOD down counter (falling-edge clocked).
// Counts MOD-1 down to 0 and wraps; borrow_out cascades into the next digit.
// Ports:
//   main_clock : clock, all state changes on the falling edge
//   clr_n      : async active-low clear (Q_output=MOD-1, flags cleared)
//   bus        : slave side of contador_decrescente_mod_if
//                load/load_val/cnt_en in; Q_output, borrow_out (comb),
//                zero (comb), wrap_pulse (reg), load_err (reg, sticky) out
module contador_decrescente_mod #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned MOD   = 10
) (
  input  logic                        main_clock,
  input  logic                        clr_n,
  contador_decrescente_mod_if.slave   bus
);

  // Terminal value and an extended-width modulus so MOD == 2**WIDTH compares correctly
  localparam logic [WIDTH-1:0] TOP_VAL = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic             r_err;

  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic             w_is_zero;
  logic             w_load_ok;
  logic             w_wrap_next;
  logic             w_err_next;

  // Next-state: load beats count beats hold
  always_comb begin
    w_next      = r_q;
    w_wrap_next = 1'b0;
    w_err_next  = r_err;
    w_is_zero   = (r_q == '0);
    w_load_ok   = ({1'b0, bus.load_val} < MOD_EXT);
    if (bus.load) begin
      if (w_load_ok) begin
        w_next = bus.load_val;
      end else begin
        w_next     = TOP_VAL;
        w_err_next = 1'b1;
      end
    end else if (bus.cnt_en) begin
      if (w_is_zero) begin
        w_next      = TOP_VAL;
        w_wrap_next = 1'b1;
      end else begin
        w_next = r_q - WIDTH'(1);
      end
    end
  end

  // JK excitation: set bits that must rise, toggle-off bits that must fall
  always_comb begin
    w_j = w_next & ~r_q;
    w_k = ~w_next & r_q;
  end

  // One JK flip-flop per bit; clear forces the terminal value (MOD-1)
  always_ff @(negedge main_clock or negedge clr_n) begin
    if (!clr_n) begin
      r_q <= TOP_VAL;
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        r_q[i] <= (w_j[i] & ~r_q[i]) | (~w_k[i] & r_q[i]);
      end
    end
  end

  // Status flags share the counter's edge and clear
  always_ff @(negedge main_clock or negedge clr_n) begin
    if (!clr_n) begin
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_wrap <= w_wrap_next;
      r_err  <= w_err_next;
    end
  end

  // borrow_out stays combinational so the next digit steps on this wrap edge
  assign bus.Q_output   = r_q;
  assign bus.zero       = w_is_zero;
  assign bus.borrow_out = bus.cnt_en & ~bus.load & w_is_zero;
  assign bus.wrap_pulse = r_wrap;
  assign bus.load_err   = r_err;

endmodule

// File: tb/tb_contador_decrescente_mod.sv
// Self-checking bench for contador_decrescente_mod: directed scenarios plus
// randomized load/count traffic compared with an arithmetic reference model.
module tb_contador_decrescente_mod;
  localparam int unsigned W   = 5;
  localparam int unsigned M   = 10;
  localparam int unsigned M32 = 32;

  logic main_clock;
  logic clr_n;

  contador_decrescente_mod_if #(.WIDTH(W)) if_m ();
  contador_decrescente_mod_if #(.WIDTH(W)) if_u ();
  contador_decrescente_mod_if #(.WIDTH(W)) if_t ();
  contador_decrescente_mod_if #(.WIDTH(W)) if_w ();

  contador_decrescente_mod #(.WIDTH(W), .MOD(M))   dut   (.main_clock(main_clock), .clr_n(clr_n), .bus(if_m));
  contador_decrescente_mod #(.WIDTH(W), .MOD(M))   units (.main_clock(main_clock), .clr_n(clr_n), .bus(if_u));
  contador_decrescente_mod #(.WIDTH(W), .MOD(M))   tens  (.main_clock(main_clock), .clr_n(clr_n), .bus(if_t));
  contador_decrescente_mod #(.WIDTH(W), .MOD(M32)) dut32 (.main_clock(main_clock), .clr_n(clr_n), .bus(if_w));

  assign if_t.cnt_en = if_u.borrow_out;

  initial main_clock = 1'b1;
  always #5 main_clock = ~main_clock;

  int checks = 0;
  int errors = 0;

  // Reference model of the MOD=10 counter
  int m_q;
  bit m_wrap;
  bit m_err;

  task automatic model_reset();
    m_q = M - 1; m_wrap = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step(input bit ld, input int v, input bit en);
    if (ld) begin
      m_wrap = 1'b0;
      if (v < int'(M)) m_q = v;
      else begin m_q = M - 1; m_err = 1'b1; end
    end else if (en) begin
      m_wrap = (m_q == 0);
      m_q    = (m_q == 0) ? int'(M) - 1 : m_q - 1;
    end else begin
      m_wrap = 1'b0;
    end
  endtask

  task automatic drive(input bit ld, input int v, input bit en);
    if_m.load = ld; if_m.load_val = W'(v); if_m.cnt_en = en;
  endtask

  // Apply inputs, take one falling edge, sample 1 ns later, advance model
  task automatic tick(input bit ld, input int v, input bit en);
    drive(ld, v, en);
    @(negedge main_clock); #1;
    model_step(ld, v, en);
  endtask

  task automatic pulse_clear();
    @(posedge main_clock);
    clr_n = 1'b0; #1;
    model_reset();
    #2 clr_n = 1'b1;
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    drive(0, 0, 0);
    #12;
    model_reset();
    checks++; if (if_m.Q_output !== W'(9)) begin errors++; $display("FAIL reset_q got %0d exp 9", if_m.Q_output); end
    checks++; if (if_m.wrap_pulse !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b exp 0", if_m.wrap_pulse); end
    checks++; if (if_m.load_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", if_m.load_err); end
    checks++; if (if_m.zero !== 1'b0) begin errors++; $display("FAIL reset_zero got %b exp 0", if_m.zero); end
    clr_n = 1'b1;
  endtask

  task automatic test_count();
    int nw = 0;
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, 1);
      if (if_m.wrap_pulse === 1'b1) nw++;
      checks++; if (if_m.Q_output !== W'(m_q)) begin errors++; $display("FAIL count_q[%0d] got %0d exp %0d", i, if_m.Q_output, m_q); end
      checks++; if (if_m.wrap_pulse !== m_wrap) begin errors++; $display("FAIL count_wrap[%0d] got %b exp %b", i, if_m.wrap_pulse, m_wrap); end
      checks++; if (if_m.zero !== (m_q == 0)) begin errors++; $display("FAIL count_zero[%0d] got %b exp %b", i, if_m.zero, (m_q == 0)); end
    end
    checks++; if (nw !== 1) begin errors++; $display("FAIL count_wrap_total got %0d exp 1", nw); end
  endtask

  task automatic test_hold_borrow();
    tick(1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0);
      checks++; if (if_m.Q_output !== W'(0)) begin errors++; $display("FAIL hold_q[%0d] got %0d exp 0", i, if_m.Q_output); end
      checks++; if (if_m.borrow_out !== 1'b0) begin errors++; $display("FAIL hold_borrow[%0d] got %b exp 0", i, if_m.borrow_out); end
      checks++; if (if_m.zero !== 1'b1) begin errors++; $display("FAIL hold_zero[%0d] got %b exp 1", i, if_m.zero); end
    end
    drive(0, 0, 1); #1;
    checks++; if (if_m.borrow_out !== 1'b1) begin errors++; $display("FAIL borrow_comb got %b exp 1", if_m.borrow_out); end
    tick(0, 0, 1);
    checks++; if (if_m.Q_output !== W'(9)) begin errors++; $display("FAIL borrow_wrap_q got %0d exp 9", if_m.Q_output); end
    checks++; if (if_m.wrap_pulse !== 1'b1) begin errors++; $display("FAIL borrow_wrap_pulse got %b exp 1", if_m.wrap_pulse); end
  endtask

  task automatic test_load();
    tick(1, 5, 0);
    checks++; if (if_m.Q_output !== W'(5)) begin errors++; $display("FAIL load5_q got %0d exp 5", if_m.Q_output); end
    checks++; if (if_m.load_err !== 1'b0) begin errors++; $display("FAIL load5_err got %b exp 0", if_m.load_err); end
    tick(1, 12, 0);
    checks++; if (if_m.Q_output !== W'(9)) begin errors++; $display("FAIL load12_q got %0d exp 9", if_m.Q_output); end
    checks++; if (if_m.load_err !== 1'b1) begin errors++; $display("FAIL load12_err got %b exp 1", if_m.load_err); end
    for (int i = 0; i < 20; i++) tick(0, 0, 1'($urandom_range(0, 1)));
    checks++; if (if_m.Q_output !== W'(m_q)) begin errors++; $display("FAIL load_after_q got %0d exp %0d", if_m.Q_output, m_q); end
    checks++; if (if_m.load_err !== 1'b1) begin errors++; $display("FAIL load_sticky got %b exp 1", if_m.load_err); end
  endtask

  task automatic test_load_vs_count();
    tick(1, 0, 0);
    drive(1, 3, 1); #1;
    checks++; if (if_m.borrow_out !== 1'b0) begin errors++; $display("FAIL conflict_borrow got %b exp 0", if_m.borrow_out); end
    tick(1, 3, 1);
    checks++; if (if_m.Q_output !== W'(3)) begin errors++; $display("FAIL conflict_q got %0d exp 3", if_m.Q_output); end
    checks++; if (if_m.wrap_pulse !== 1'b0) begin errors++; $display("FAIL conflict_wrap got %b exp 0", if_m.wrap_pulse); end
  endtask

  task automatic test_async_clear();
    // Clear while wrap_pulse is high
    tick(1, 0, 0);
    tick(0, 0, 1);
    drive(0, 0, 0); #1;
    clr_n = 1'b0; #1;
    model_reset();
    checks++; if (if_m.wrap_pulse !== 1'b0) begin errors++; $display("FAIL aclr_wrap got %b exp 0", if_m.wrap_pulse); end
    #1 clr_n = 1'b1;
    // Clear with Q=4 and load_err set, 2 ns after a falling edge
    tick(1, 20, 0);
    tick(1, 4, 0);
    checks++; if (if_m.Q_output !== W'(4)) begin errors++; $display("FAIL aclr_pre_q got %0d exp 4", if_m.Q_output); end
    drive(0, 0, 0); #1;
    clr_n = 1'b0; #1;
    model_reset();
    checks++; if (if_m.Q_output !== W'(9)) begin errors++; $display("FAIL aclr_q got %0d exp 9", if_m.Q_output); end
    checks++; if (if_m.load_err !== 1'b0) begin errors++; $display("FAIL aclr_err got %b exp 0", if_m.load_err); end
    checks++; if (if_m.wrap_pulse !== 1'b0) begin errors++; $display("FAIL aclr_wrap2 got %b exp 0", if_m.wrap_pulse); end
    // A load during clear is ignored
    drive(1, 3, 1);
    @(negedge main_clock); #1;
    checks++; if (if_m.Q_output !== W'(9)) begin errors++; $display("FAIL aclr_hold_q got %0d exp 9", if_m.Q_output); end
    drive(0, 0, 0);
    clr_n = 1'b1;
    tick(0, 0, 0);
    checks++; if (if_m.Q_output !== W'(m_q)) begin errors++; $display("FAIL aclr_release_q got %0d exp %0d", if_m.Q_output, m_q); end
  endtask

  task automatic test_cascade();
    int cnt = 99;
    pulse_clear();
    checks++; if (int'(if_t.Q_output) * 10 + int'(if_u.Q_output) !== 99) begin errors++; $display("FAIL cascade_start got %0d%0d exp 99", if_t.Q_output, if_u.Q_output); end
    if_u.cnt_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge main_clock); #1;
      cnt = (cnt + 99) % 100;
      checks++;
      if (if_u.Q_output !== W'(cnt % 10) || if_t.Q_output !== W'(cnt / 10)) begin
        errors++; $display("FAIL cascade[%0d] got %0d%0d exp %0d", i, if_t.Q_output, if_u.Q_output, cnt);
      end
    end
    if_u.cnt_en = 1'b0;
    checks++; if (int'(if_t.Q_output) * 10 + int'(if_u.Q_output) !== 99) begin errors++; $display("FAIL cascade_end got %0d%0d exp 99", if_t.Q_output, if_u.Q_output); end
  endtask

  task automatic test_mod32();
    pulse_clear();
    checks++; if (if_w.Q_output !== W'(31)) begin errors++; $display("FAIL m32_reset got %0d exp 31", if_w.Q_output); end
    if_w.load = 1'b1; if_w.load_val = W'(0);
    @(negedge main_clock); #1;
    if_w.load = 1'b0; if_w.cnt_en = 1'b1;
    @(negedge main_clock); #1;
    checks++; if (if_w.Q_output !== W'(31)) begin errors++; $display("FAIL m32_wrap_q got %0d exp 31", if_w.Q_output); end
    checks++; if (if_w.wrap_pulse !== 1'b1) begin errors++; $display("FAIL m32_wrap_pulse got %b exp 1", if_w.wrap_pulse); end
    if_w.cnt_en = 1'b0; if_w.load = 1'b1; if_w.load_val = W'(31);
    @(negedge main_clock); #1;
    if_w.load = 1'b0;
    checks++; if (if_w.load_err !== 1'b0) begin errors++; $display("FAIL m32_load_err got %b exp 0", if_w.load_err); end
    checks++; if (if_w.Q_output !== W'(31)) begin errors++; $display("FAIL m32_load_q got %0d exp 31", if_w.Q_output); end
  endtask

  task automatic test_random();
    pulse_clear();
    drive(0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      bit ld = ($urandom_range(0, 7) == 0);
      int v  = int'($urandom_range(0, 31));
      bit en = ($urandom_range(0, 3) != 0);
      drive(ld, v, en); #1;
      checks++; if (if_m.borrow_out !== (en && !ld && m_q == 0)) begin errors++; $display("FAIL rnd_borrow[%0d] got %b", i, if_m.borrow_out); end
      @(negedge main_clock); #1;
      model_step(ld, v, en);
      checks++;
      if (if_m.Q_output !== W'(m_q) || if_m.wrap_pulse !== m_wrap || if_m.load_err !== m_err || if_m.zero !== (m_q == 0)) begin
        errors++;
        $display("FAIL rnd[%0d] got q=%0d w=%b e=%b exp q=%0d w=%b e=%b", i, if_m.Q_output, if_m.wrap_pulse, if_m.load_err, m_q, m_wrap, m_err);
      end
    end
  endtask

  initial begin
    if_u.load = 1'b0; if_u.load_val = '0; if_u.cnt_en = 1'b0;
    if_t.load = 1'b0; if_t.load_val = '0;
    if_w.load = 1'b0; if_w.load_val = '0; if_w.cnt_en = 1'b0;
    test_reset();
    test_count();
    test_hold_borrow();
    test_load();
    test_load_vs_count();
    test_async_clear();
    test_cascade();
    test_mod32();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
